branch_resolve_unit: RTL and testbench

- Execute-stage counterpart to the fetch/decode direction predictor.
- Latches the decoded branch and its D-stage prediction across the D→E boundary, then evaluates the real condition on forwarded operands.
- Emits a one-cycle training pulse back to the predictor.
- On a misprediction, runs a redirect FSM that waits for the MIPS delay slot and then holds a PC-redirect request until fetch accepts it. Keeps saturating branch and mispredict counters.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates the real branch condition,
// trains the predictor and requests a fetch redirect on a misprediction.
module branch_resolve_unit #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             exc_flush,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      instrD,
    input  logic [31:0]      pcD,
    input  logic [31:0]      srcaE,
    input  logic [31:0]      srcbE,
    input  logic             ds_inD,
    input  logic             redirect_ready,
    output logic             branchE,
    output logic             actual_takeE,
    output logic [31:0]      pcE,
    output logic             mispredictE,
    output logic             nullify_dsD,
    output logic             hold_req,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_DS = 2'd1;
    localparam logic [1:0] S_REDIR   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // E register contents
    logic        valid_q;
    logic        pred_q;
    logic [5:0]  op_q;
    logic [4:0]  rt_q;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;

    logic [1:0]  state;
    logic [31:0] redir_pc_q;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;

    logic [31:0] offset;
    logic        legal;
    logic        cond;
    logic        a_zero;
    logic        a_neg;
    logic        likely;
    logic        resolve;
    logic        mispredict;
    logic [31:0] fix_pc;
    logic        unused_rs;

    assign offset    = {{14{instrD[15]}}, instrD[15:0], 2'b00};
    assign unused_rs = ^instrD[25:21];

    // D->E pipeline register; flushes only drop the valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
            op_q    <= '0;
            rt_q    <= '0;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else if (exc_flush || flushE) begin
            valid_q <= 1'b0;
        end else if (!stallE) begin
            valid_q <= branchD;
            pred_q  <= pred_takeD;
            op_q    <= instrD[31:26];
            rt_q    <= instrD[20:16];
            pc_q    <= pcD;
            tgt_q   <= pcD + 32'd4 + offset;
        end
    end

    assign a_zero = (srcaE == 32'd0);
    assign a_neg  = srcaE[31];

    // Branch condition on forwarded operands; unknown opcodes are not branches
    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        unique case (op_q)
            OP_BEQ:    cond = (srcaE == srcbE);
            OP_BNE:    cond = (srcaE != srcbE);
            OP_BLEZ:   cond = a_neg | a_zero;
            OP_BGTZ:   cond = !a_neg & !a_zero;
            OP_REGIMM: cond = rt_q[0] ? !a_neg : a_neg;
            default:   legal = 1'b0;
        endcase
    end

    assign likely     = (op_q == OP_REGIMM) & rt_q[1];
    assign resolve    = valid_q & legal & !stallE & (state == S_IDLE);
    assign mispredict = resolve & (cond != pred_q);
    assign fix_pc     = cond ? tgt_q : pc_q + 32'd8;

    // Redirect sequencer: wait for the delay slot, then hold until fetch takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            redir_pc_q <= RESET_PC;
        end else if (exc_flush) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mispredict) begin
                        redir_pc_q <= fix_pc;
                        state      <= ds_inD ? S_REDIR : S_WAIT_DS;
                    end
                end
                S_WAIT_DS: begin
                    if (ds_inD) state <= S_REDIR;
                end
                S_REDIR: begin
                    if (redirect_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
            mcnt <= '0;
        end else begin
            if (resolve && bcnt != CNT_MAX)    bcnt <= bcnt + CNT_ONE;
            if (mispredict && mcnt != CNT_MAX) mcnt <= mcnt + CNT_ONE;
        end
    end

    assign branchE        = resolve;
    assign actual_takeE   = resolve & cond;
    assign pcE            = pc_q;
    assign mispredictE    = mispredict;
    assign nullify_dsD    = resolve & likely & !cond;
    assign hold_req       = (state != S_IDLE);
    assign redirect_valid = (state == S_REDIR);
    assign redirect_pc    = redir_pc_q;
    assign branch_cnt     = bcnt;
    assign mispred_cnt    = mcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus
// randomized branches checked against a behavioural branch model.
module tb_branch_resolve_unit;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst, stallE, flushE, exc_flush, branchD, pred_takeD;
    logic [31:0] instrD, pcD, srcaE, srcbE;
    logic        ds_inD, redirect_ready;
    logic        branchE, actual_takeE, mispredictE, nullify_dsD;
    logic        hold_req, redirect_valid;
    logic [31:0] pcE, redirect_pc;
    logic [3:0]  branch_cnt, mispred_cnt;

    branch_resolve_unit #(.CNT_W(4), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
        .exc_flush(exc_flush), .branchD(branchD), .pred_takeD(pred_takeD),
        .instrD(instrD), .pcD(pcD), .srcaE(srcaE), .srcbE(srcbE),
        .ds_inD(ds_inD), .redirect_ready(redirect_ready),
        .branchE(branchE), .actual_takeE(actual_takeE), .pcE(pcE),
        .mispredictE(mispredictE), .nullify_dsD(nullify_dsD),
        .hold_req(hold_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        take;
        logic [31:0] pc;
        logic        misp;
        logic        nul;
    } exp_t;

    exp_t        eq[$];
    logic [31:0] rq[$];
    int          errors = 0;
    int          checks = 0;
    int          nb = 0;
    int          nm = 0;

    task automatic chk(string nm_s, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm_s, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(int n);
        return (n > 15) ? 15 : n;
    endfunction

    // Architectural meaning of each MIPS conditional branch
    function automatic logic ref_cond(logic [5:0] op, logic [4:0] rt,
                                      logic [31:0] a, logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            6'd4:    return a == b;
            6'd5:    return a != b;
            6'd6:    return sa <= 0;
            6'd7:    return sa > 0;
            6'd1:    return rt[0] ? (sa >= 0) : (sa < 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_reset();
        chk("rst_branchE", 32'(branchE), 0);
        chk("rst_take", 32'(actual_takeE), 0);
        chk("rst_misp", 32'(mispredictE), 0);
        chk("rst_nullify", 32'(nullify_dsD), 0);
        chk("rst_hold", 32'(hold_req), 0);
        chk("rst_rvalid", 32'(redirect_valid), 0);
        chk("rst_pcE", pcE, RPC);
        chk("rst_rpc", redirect_pc, RPC);
        chk("rst_bcnt", 32'(branch_cnt), 0);
        chk("rst_mcnt", 32'(mispred_cnt), 0);
    endtask

    // mode 0: normal redirect, 1: exc_flush while redirecting,
    // 2: reset while waiting for the delay slot (needs dsdel >= 1)
    task automatic issue(logic [5:0] op, logic [4:0] rt, logic [15:0] imm,
                         logic [31:0] pc, logic pred, logic [31:0] a,
                         logic [31:0] b, int sdel, int dsdel, int rdel,
                         int mode);
        logic        c, legal, misp, lk;
        logic [31:0] tgt;
        int          off;
        legal = (op == 6'd1) || (op >= 6'd4 && op <= 6'd7);
        c     = ref_cond(op, rt, a, b);
        lk    = (op == 6'd1) && rt[1];
        misp  = legal && (c != pred);
        off   = $signed(imm);
        tgt   = c ? pc + 32'd4 + 32'(off * 4) : pc + 32'd8;
        if (legal) begin
            eq.push_back('{c, pc, misp, lk && !c});
            nb++;
            if (misp) nm++;
            if (misp && mode == 0) rq.push_back(tgt);
        end
        branchD = 1'b1;
        instrD = {op, 5'd3, rt, imm};
        pcD = pc;
        pred_takeD = pred;
        srcaE = a;
        srcbE = b;
        stallE = 1'b0;
        ds_inD = 1'b0;
        redirect_ready = 1'($urandom_range(0, 1));
        tick();
        branchD = 1'b0;
        instrD = $urandom();
        pcD = $urandom();
        pred_takeD = 1'($urandom_range(0, 1));
        stallE = 1'b1;
        repeat (sdel) tick();
        stallE = 1'b0;
        ds_inD = (dsdel == 0);
        tick();
        redirect_ready = 1'b0;
        if (misp) begin
            for (int i = 0; i < dsdel; i++) begin
                chk("wait_rvalid", 32'(redirect_valid), 0);
                chk("wait_hold", 32'(hold_req), 1);
                if (mode == 2) begin
                    ds_inD = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk_reset();
                    nb = 0;
                    nm = 0;
                    return;
                end
                ds_inD = (i == dsdel - 1);
                tick();
            end
            ds_inD = 1'b0;
            for (int i = 0; i <= rdel; i++) begin
                chk("redir_valid", 32'(redirect_valid), 1);
                chk("redir_pc", redirect_pc, tgt);
                chk("redir_hold", 32'(hold_req), 1);
                if (i == rdel) begin
                    if (mode == 1) exc_flush = 1'b1;
                    else redirect_ready = 1'b1;
                end
                tick();
            end
            exc_flush = 1'b0;
            redirect_ready = 1'b0;
            chk("done_rvalid", 32'(redirect_valid), 0);
            chk("done_hold", 32'(hold_req), 0);
        end
    endtask

    // Monitor: compares every training pulse and redirect handshake
    initial begin
        exp_t        e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (branchE) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_branchE: got 1 expected 0");
                end else begin
                    e = eq.pop_front();
                    chk("take", 32'(actual_takeE), 32'(e.take));
                    chk("pcE", pcE, e.pc);
                    chk("misp", 32'(mispredictE), 32'(e.misp));
                    chk("nullify", 32'(nullify_dsD), 32'(e.nul));
                end
            end else if (actual_takeE || mispredictE || nullify_dsD) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse: got %b%b%b expected 000",
                         actual_takeE, mispredictE, nullify_dsD);
            end
            if (redirect_valid && redirect_ready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_redirect: got %h expected none",
                             redirect_pc);
                end else begin
                    r = rq.pop_front();
                    chk("hs_pc", redirect_pc, r);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[8];
        logic [31:0] a;
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd2, 6'd8};
        rst = 1'b1; stallE = 0; flushE = 0; exc_flush = 0; branchD = 0;
        pred_takeD = 0; instrD = 0; pcD = 0; srcaE = 0; srcbE = 0;
        ds_inD = 0; redirect_ready = 0;
        tick();
        tick();
        chk_reset();
        rst = 1'b0;

        issue(6'd4, 5'd0, 16'h0010, 32'h1000, 0, 5, 5, 0, 0, 1, 0);
        issue(6'd5, 5'd0, 16'h0040, 32'h2000, 1, 7, 7, 0, 0, 0, 0);
        issue(6'd7, 5'd0, 16'h0008, 32'h3000, 1, 3, 0, 0, 0, 0, 0);
        chk("bcnt_dir", 32'(branch_cnt), 32'(sat(nb)));
        issue(6'd4, 5'd0, 16'hFFF0, 32'h4000, 0, 9, 9, 0, 3, 4, 0);
        issue(6'd1, 5'd2, 16'h0020, 32'h5000, 0, 1, 0, 0, 0, 0, 0);
        issue(6'd1, 5'd18, 16'h0020, 32'h5100, 1, 32'h8000_0000, 0,
              0, 0, 0, 0);
        issue(6'd6, 5'd0, 16'h0004, 32'h6000, 0, 0, 0, 2, 1, 0, 0);
        issue(6'd4, 5'd0, 16'h0004, 32'h7000, 0, 1, 1, 0, 0, 2, 1);
        chk("mcnt_dir", 32'(mispred_cnt), 32'(sat(nm)));
        issue(6'd4, 5'd0, 16'h0004, 32'h8000, 0, 1, 1, 0, 3, 0, 2);

        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 5));
            case (a)
                0: a = 0;
                1: a = 1;
                2: a = 32'h8000_0000;
                3: a = 32'hFFFF_FFFF;
                4: a = 7;
                default: a = $urandom();
            endcase
            issue(ops[$urandom_range(0, 7)], 5'($urandom()),
                  16'($urandom()), $urandom() & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), a,
                  ($urandom_range(0, 1) == 1) ? a : $urandom(),
                  $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0);
        end
        chk("bcnt_rand", 32'(branch_cnt), 32'(sat(nb)));
        chk("mcnt_rand", 32'(mispred_cnt), 32'(sat(nm)));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        nb = 0;
        nm = 0;
        for (int n = 1; n <= 17; n++) begin
            issue(6'd4, 5'd0, 16'h0004, 32'h9000, 0, 1, 1, 0, 0, 0, 0);
            if (n == 14 || n == 16 || n == 17)
                chk("mcnt_sat", 32'(mispred_cnt), 32'(sat(nm)));
        end
        chk("bcnt_sat", 32'(branch_cnt), 32'(sat(nb)));

        tick();
        chk("eq_empty", 32'(eq.size()), 0);
        chk("rq_empty", 32'(rq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
